matrix_slot_manager: RTL and testbench

- Owns the matrix storage table: hands out BRAM regions (slots) to producer modes (generate, input) through the alloc handshake, records dimensions on commit, and serves reads to display and calculate modes.
- Sits between the mode FSMs and BRAM.
- Each slot is a fixed region of SLOT_SIZE elements.
- Eviction is round-robin when no slot is free.

---
 rtl/matrix_slot_manager_pkg.sv | 26 ++
 rtl/matrix_slot_manager_if.sv | 43 ++++
 rtl/matrix_slot_manager_slot_picker.sv | 46 ++++
 rtl/matrix_slot_manager.sv | 215 +++++++++++++++++++++
 tb/tb_matrix_slot_manager.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_slot_manager_pkg.sv
// Shared constants, error codes and state encodings for the matrix slot table.
// Every slot owns a fixed MAX_DIM*MAX_DIM element region of BRAM.
package matrix_slot_manager_pkg;

    localparam int ADDR_WIDTH = 10;
    localparam int NUM_SLOTS  = 8;
    localparam int MAX_DIM    = 5;
    localparam int SLOT_SIZE  = MAX_DIM * MAX_DIM;

    localparam logic [3:0] ERR_NONE       = 4'd0;
    localparam logic [3:0] ERR_NO_SLOT    = 4'd1;
    localparam logic [3:0] ERR_BAD_COMMIT = 4'd2;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        RESERVED = 2'd1,
        VALID    = 2'd2
    } slot_state_e;

    typedef enum logic [1:0] {
        A_IDLE   = 2'd0,
        A_SEARCH = 2'd1,
        A_HOLD   = 2'd2
    } alloc_state_e;

endpackage

// File: rtl/matrix_slot_manager_if.sv
// Handshake bundle between the mode FSMs (master) and the slot manager (slave).
interface matrix_slot_manager_if #(
    parameter int ADDR_WIDTH = matrix_slot_manager_pkg::ADDR_WIDTH
);
    logic                  alloc_req;
    logic                  alloc_valid;
    logic [3:0]            alloc_slot;
    logic [ADDR_WIDTH-1:0] alloc_addr;
    logic                  alloc_err;

    logic                  commit_req;
    logic [3:0]            commit_slot;
    logic [3:0]            commit_m;
    logic [3:0]            commit_n;
    logic [ADDR_WIDTH-1:0] commit_addr;
    logic                  commit_err;

    logic                  free_req;
    logic [3:0]            free_slot;

    logic [3:0]            query_slot;
    logic                  query_valid;
    logic [3:0]            query_m;
    logic [3:0]            query_n;
    logic [ADDR_WIDTH-1:0] query_addr;

    logic [4:0]            valid_count;
    logic [3:0]            error_code;

    modport master (
        output alloc_req, commit_req, commit_slot, commit_m, commit_n, commit_addr,
               free_req, free_slot, query_slot,
        input  alloc_valid, alloc_slot, alloc_addr, alloc_err, commit_err,
               query_valid, query_m, query_n, query_addr, valid_count, error_code
    );

    modport slave (
        input  alloc_req, commit_req, commit_slot, commit_m, commit_n, commit_addr,
               free_req, free_slot, query_slot,
        output alloc_valid, alloc_slot, alloc_addr, alloc_err, commit_err,
               query_valid, query_m, query_n, query_addr, valid_count, error_code
    );
endinterface

// File: rtl/matrix_slot_manager_slot_picker.sv
// Combinational slot chooser: lowest-index FREE slot, otherwise the first VALID
// slot at or after rr_ptr (circular), which the caller then evicts.
module matrix_slot_manager_slot_picker #(
    parameter int NUM_SLOTS = matrix_slot_manager_pkg::NUM_SLOTS
) (
    input  logic [2*NUM_SLOTS-1:0] state_i,
    input  logic [3:0]             rr_ptr_i,
    output logic                   hit_o,
    output logic [3:0]             idx_o,
    output logic                   evict_o
);
    import matrix_slot_manager_pkg::*;

    logic       free_hit;
    logic [3:0] free_idx;
    logic       valid_hit;
    logic [3:0] valid_idx;
    int         j;

    always_comb begin
        free_hit  = 1'b0;
        free_idx  = 4'd0;
        valid_hit = 1'b0;
        valid_idx = 4'd0;
        j         = 0;
        // Descending scans so the last match written is the preferred one.
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (state_i[2*i +: 2] == FREE) begin
                free_hit = 1'b1;
                free_idx = 4'(i);
            end
        end
        for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
            j = (int'(rr_ptr_i) + k) % NUM_SLOTS;
            if (state_i[2*j +: 2] == VALID) begin
                valid_hit = 1'b1;
                valid_idx = 4'(j);
            end
        end
    end

    assign hit_o   = free_hit | valid_hit;
    assign idx_o   = free_hit ? free_idx : valid_idx;
    assign evict_o = ~free_hit & valid_hit;

endmodule

// File: rtl/matrix_slot_manager.sv
// Matrix storage table: grants BRAM slots to producers, records dimensions on
// commit, releases slots on free and serves registered read-back queries.
module matrix_slot_manager #(
    parameter int ADDR_WIDTH = matrix_slot_manager_pkg::ADDR_WIDTH,
    parameter int NUM_SLOTS  = matrix_slot_manager_pkg::NUM_SLOTS,
    parameter int SLOT_SIZE  = matrix_slot_manager_pkg::SLOT_SIZE,
    parameter int MAX_DIM    = matrix_slot_manager_pkg::MAX_DIM
) (
    input  logic                  clk,
    input  logic                  rst,
    matrix_slot_manager_if.slave  bus
);
    import matrix_slot_manager_pkg::*;

    function automatic logic [ADDR_WIDTH-1:0] slot_base(input logic [3:0] s);
        return ADDR_WIDTH'(32'(s) * 32'(SLOT_SIZE));
    endfunction

    slot_state_e           st_q [NUM_SLOTS];
    slot_state_e           st_d [NUM_SLOTS];
    logic [3:0]            m_q  [NUM_SLOTS];
    logic [3:0]            m_d  [NUM_SLOTS];
    logic [3:0]            n_q  [NUM_SLOTS];
    logic [3:0]            n_d  [NUM_SLOTS];

    alloc_state_e          fsm_q, fsm_d;
    logic [3:0]            rr_q, rr_d;
    logic                  alloc_valid_q, alloc_valid_d;
    logic                  alloc_err_q, alloc_err_d;
    logic [3:0]            alloc_slot_q, alloc_slot_d;
    logic [ADDR_WIDTH-1:0] alloc_addr_q, alloc_addr_d;
    logic                  commit_err_q, commit_err_d;
    logic [3:0]            err_q, err_d;
    logic [4:0]            vc_q, vc_d;
    logic                  qv_q, qv_d;
    logic [3:0]            qm_q, qm_d;
    logic [3:0]            qn_q, qn_d;
    logic [ADDR_WIDTH-1:0] qa_q, qa_d;

    logic [2*NUM_SLOTS-1:0] st_vec;
    logic                   pick_hit;
    logic [3:0]             pick_idx;
    logic                   pick_evict;
    logic                   dims_ok;
    logic                   commit_ok;
    logic                   free_blocked;

    always_comb begin
        st_vec = '0;
        for (int i = 0; i < NUM_SLOTS; i++) st_vec[2*i +: 2] = st_q[i];
    end

    matrix_slot_manager_slot_picker #(.NUM_SLOTS(NUM_SLOTS)) u_picker (
        .state_i  (st_vec),
        .rr_ptr_i (rr_q),
        .hit_o    (pick_hit),
        .idx_o    (pick_idx),
        .evict_o  (pick_evict)
    );

    always_comb begin
        st_d          = st_q;
        m_d           = m_q;
        n_d           = n_q;
        fsm_d         = fsm_q;
        rr_d          = rr_q;
        alloc_valid_d = 1'b0;
        alloc_err_d   = 1'b0;
        alloc_slot_d  = alloc_slot_q;
        alloc_addr_d  = alloc_addr_q;
        commit_err_d  = 1'b0;
        err_d         = err_q;
        commit_ok     = 1'b0;
        dims_ok       = (bus.commit_m >= 4'd1) && (bus.commit_m <= 4'(MAX_DIM)) &&
                        (bus.commit_n >= 4'd1) && (bus.commit_n <= 4'(MAX_DIM));
        free_blocked  = bus.commit_req && (bus.commit_slot == bus.free_slot);

        // Commit is applied first; a rejected reservation goes back to FREE.
        if (bus.commit_req) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (bus.commit_slot == 4'(i) && st_q[i] == RESERVED) begin
                    if (dims_ok && bus.commit_addr == slot_base(4'(i))) begin
                        commit_ok = 1'b1;
                        st_d[i]   = VALID;
                        m_d[i]    = bus.commit_m;
                        n_d[i]    = bus.commit_n;
                    end else begin
                        st_d[i] = FREE;
                    end
                end
            end
            if (commit_ok) begin
                err_d = ERR_NONE;
            end else begin
                commit_err_d = 1'b1;
                err_d        = ERR_BAD_COMMIT;
            end
        end

        if (bus.free_req && !free_blocked) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (bus.free_slot == 4'(i) && st_q[i] == VALID) begin
                    st_d[i] = FREE;
                    m_d[i]  = 4'd0;
                    n_d[i]  = 4'd0;
                end
            end
        end

        // The search sees registered state only, so it overrides a same-cycle free.
        case (fsm_q)
            A_IDLE: begin
                if (bus.alloc_req) fsm_d = A_SEARCH;
            end
            A_SEARCH: begin
                fsm_d = A_HOLD;
                if (pick_hit) begin
                    for (int i = 0; i < NUM_SLOTS; i++) begin
                        if (pick_idx == 4'(i)) begin
                            st_d[i] = RESERVED;
                            m_d[i]  = 4'd0;
                            n_d[i]  = 4'd0;
                        end
                    end
                    if (pick_evict)
                        rr_d = (pick_idx == 4'(NUM_SLOTS - 1)) ? 4'd0 : pick_idx + 4'd1;
                    alloc_valid_d = 1'b1;
                    alloc_slot_d  = pick_idx;
                    alloc_addr_d  = slot_base(pick_idx);
                end else begin
                    alloc_err_d = 1'b1;
                    err_d       = ERR_NO_SLOT;
                end
            end
            A_HOLD: begin
                if (!bus.alloc_req) fsm_d = A_IDLE;
            end
            default: fsm_d = A_IDLE;
        endcase
    end

    // valid_count is a population count of next state, so it can never exceed NUM_SLOTS.
    always_comb begin
        vc_d = 5'd0;
        for (int i = 0; i < NUM_SLOTS; i++) vc_d = vc_d + 5'(st_d[i] == VALID);
    end

    always_comb begin
        qv_d = 1'b0;
        qm_d = 4'd0;
        qn_d = 4'd0;
        qa_d = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (bus.query_slot == 4'(i)) begin
                qv_d = (st_q[i] == VALID);
                qm_d = m_q[i];
                qn_d = n_q[i];
                qa_d = slot_base(4'(i));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                st_q[i] <= FREE;
                m_q[i]  <= 4'd0;
                n_q[i]  <= 4'd0;
            end
            fsm_q         <= A_IDLE;
            rr_q          <= 4'd0;
            alloc_valid_q <= 1'b0;
            alloc_err_q   <= 1'b0;
            alloc_slot_q  <= 4'd0;
            alloc_addr_q  <= '0;
            commit_err_q  <= 1'b0;
            err_q         <= ERR_NONE;
            vc_q          <= 5'd0;
            qv_q          <= 1'b0;
            qm_q          <= 4'd0;
            qn_q          <= 4'd0;
            qa_q          <= '0;
        end else begin
            st_q          <= st_d;
            m_q           <= m_d;
            n_q           <= n_d;
            fsm_q         <= fsm_d;
            rr_q          <= rr_d;
            alloc_valid_q <= alloc_valid_d;
            alloc_err_q   <= alloc_err_d;
            alloc_slot_q  <= alloc_slot_d;
            alloc_addr_q  <= alloc_addr_d;
            commit_err_q  <= commit_err_d;
            err_q         <= err_d;
            vc_q          <= vc_d;
            qv_q          <= qv_d;
            qm_q          <= qm_d;
            qn_q          <= qn_d;
            qa_q          <= qa_d;
        end
    end

    assign bus.alloc_valid = alloc_valid_q;
    assign bus.alloc_err   = alloc_err_q;
    assign bus.alloc_slot  = alloc_slot_q;
    assign bus.alloc_addr  = alloc_addr_q;
    assign bus.commit_err  = commit_err_q;
    assign bus.error_code  = err_q;
    assign bus.valid_count = vc_q;
    assign bus.query_valid = qv_q;
    assign bus.query_m     = qm_q;
    assign bus.query_n     = qn_q;
    assign bus.query_addr  = qa_q;

endmodule

// File: tb/tb_matrix_slot_manager.sv
// Directed bench for matrix_slot_manager: allocation, eviction, commit legality,
// free, query read-back and reset during a handshake.
module tb_matrix_slot_manager;

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    matrix_slot_manager_if #(.ADDR_WIDTH(10)) bus ();

    matrix_slot_manager #(
        .ADDR_WIDTH (10),
        .NUM_SLOTS  (8),
        .SLOT_SIZE  (25),
        .MAX_DIM    (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.alloc_req   = 1'b0;
        bus.commit_req  = 1'b0;
        bus.commit_slot = 4'd0;
        bus.commit_m    = 4'd0;
        bus.commit_n    = 4'd0;
        bus.commit_addr = 10'd0;
        bus.free_req    = 1'b0;
        bus.free_slot   = 4'd0;
        bus.query_slot  = 4'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Holds alloc_req for 'hold' cycles and watches the grant window.
    task automatic do_alloc(input int hold, output int npulse, output int first_c,
                            output int nerr, output int slot, output int addr);
        npulse = 0; first_c = -1; nerr = 0; slot = -1; addr = -1;
        bus.alloc_req = 1'b1;
        for (int c = 0; c < hold + 2; c++) begin
            @(negedge clk);
            if (bus.alloc_valid) begin
                npulse++;
                if (first_c < 0) first_c = c;
                slot = int'(bus.alloc_slot);
                addr = int'(bus.alloc_addr);
            end
            if (bus.alloc_err) begin
                nerr++;
                if (first_c < 0) first_c = c;
            end
            if (c == hold - 1) bus.alloc_req = 1'b0;
        end
    endtask

    task automatic alloc_expect(input string tag, input int exp_slot);
        int np, fc, ne, s, a;
        do_alloc(2, np, fc, ne, s, a);
        check({tag, ".pulses"}, np, 1);
        check({tag, ".slot"}, s, exp_slot);
        check({tag, ".addr"}, a, exp_slot * 25);
    endtask

    task automatic do_commit(input int s, input int m, input int n, input int a,
                             input logic with_free, output int cerr);
        bus.commit_req  = 1'b1;
        bus.commit_slot = 4'(s);
        bus.commit_m    = 4'(m);
        bus.commit_n    = 4'(n);
        bus.commit_addr = 10'(a);
        bus.free_req    = with_free;
        bus.free_slot   = 4'(s);
        @(negedge clk);
        cerr = int'(bus.commit_err);
        bus.commit_req = 1'b0;
        bus.free_req   = 1'b0;
    endtask

    task automatic do_free(input int s);
        bus.free_req  = 1'b1;
        bus.free_slot = 4'(s);
        @(negedge clk);
        bus.free_req = 1'b0;
    endtask

    task automatic do_query(input int s, output int v, output int m, output int n, output int a);
        bus.query_slot = 4'(s);
        @(negedge clk);
        v = int'(bus.query_valid);
        m = int'(bus.query_m);
        n = int'(bus.query_n);
        a = int'(bus.query_addr);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int np, fc, ne, s, a, ce, v, m, n;
        rst = 1'b1;
        idle_inputs();
        do_reset();

        check("rst.alloc_valid", int'(bus.alloc_valid), 0);
        check("rst.alloc_slot", int'(bus.alloc_slot), 0);
        check("rst.alloc_addr", int'(bus.alloc_addr), 0);
        check("rst.valid_count", int'(bus.valid_count), 0);
        check("rst.error_code", int'(bus.error_code), 0);
        check("rst.commit_err", int'(bus.commit_err), 0);

        // Request held four cycles: one grant, visible two cycles after assertion
        do_alloc(4, np, fc, ne, s, a);
        check("a0.pulses", np, 1);
        check("a0.latency", fc, 1);
        check("a0.err", ne, 0);
        check("a0.slot", s, 0);
        check("a0.addr", a, 0);
        do_commit(0, 3, 3, 0, 1'b0, ce);
        check("c0.err", ce, 0);
        check("c0.valid_count", int'(bus.valid_count), 1);
        check("c0.error_code", int'(bus.error_code), 0);
        do_query(0, v, m, n, a);
        check("q0.valid", v, 1);
        check("q0.m", m, 3);
        check("q0.n", n, 3);
        check("q0.addr", a, 0);

        // Fill the remaining slots
        for (int i = 1; i < 8; i++) begin
            alloc_expect($sformatf("fill%0d", i), i);
            do_commit(i, 2, 2, i * 25, 1'b0, ce);
            check($sformatf("fill%0d.cerr", i), ce, 0);
        end
        check("full.valid_count", int'(bus.valid_count), 8);

        // Round-robin eviction: slot 0 then slot 1
        alloc_expect("ev0", 0);
        check("ev0.valid_count", int'(bus.valid_count), 7);
        do_commit(0, 1, 1, 0, 1'b0, ce);
        check("ev0.recommit_vc", int'(bus.valid_count), 8);
        alloc_expect("ev1", 1);
        check("ev1.valid_count", int'(bus.valid_count), 7);
        do_commit(1, 4, 5, 25, 1'b0, ce);
        check("ev1.recommit_vc", int'(bus.valid_count), 8);
        do_query(1, v, m, n, a);
        check("q1.valid", v, 1);
        check("q1.m", m, 4);
        check("q1.n", n, 5);
        check("q1.addr", a, 25);
        do_query(9, v, m, n, a);
        check("q9.sum", v + m + n + a, 0);

        // Free, repeated free, and commit+free on the same VALID slot
        do_free(3);
        check("free3.vc", int'(bus.valid_count), 7);
        do_query(3, v, m, n, a);
        check("free3.qvalid", v, 0);
        do_free(3);
        check("free3b.vc", int'(bus.valid_count), 7);
        do_commit(4, 2, 2, 100, 1'b1, ce);
        check("cf4.cerr", ce, 1);
        check("cf4.error_code", int'(bus.error_code), 2);
        check("cf4.vc", int'(bus.valid_count), 7);
        do_query(4, v, m, n, a);
        check("cf4.qvalid", v, 1);
        check("cf4.qm", m, 2);

        // All slots reserved: the ninth request is refused
        do_reset();
        for (int i = 0; i < 8; i++) alloc_expect($sformatf("res%0d", i), i);
        do_alloc(2, np, fc, ne, s, a);
        check("nos.pulses", np, 0);
        check("nos.err", ne, 1);
        check("nos.latency", fc, 1);
        check("nos.error_code", int'(bus.error_code), 1);
        check("nos.alloc_slot_held", int'(bus.alloc_slot), 7);
        check("nos.vc", int'(bus.valid_count), 0);

        // Illegal commits release the reservation
        do_reset();
        alloc_expect("bc.a0", 0);
        alloc_expect("bc.a1", 1);
        alloc_expect("bc.a2", 2);
        do_commit(2, 6, 3, 50, 1'b0, ce);
        check("bc.m6.cerr", ce, 1);
        check("bc.m6.error_code", int'(bus.error_code), 2);
        alloc_expect("bc.realloc2", 2);
        do_commit(1, 3, 3, 24, 1'b0, ce);
        check("bc.addr.cerr", ce, 1);
        alloc_expect("bc.realloc1", 1);
        do_commit(2, 3, 4, 50, 1'b0, ce);
        check("bc.ok.cerr", ce, 0);
        check("bc.ok.error_code", int'(bus.error_code), 0);
        check("bc.ok.vc", int'(bus.valid_count), 1);

        // Reset between grant and commit drops everything
        do_reset();
        alloc_expect("rh.a0", 0);
        do_commit(0, 3, 3, 0, 1'b0, ce);
        check("rh.vc1", int'(bus.valid_count), 1);
        alloc_expect("rh.a1", 1);
        do_reset();
        check("rh.vc0", int'(bus.valid_count), 0);
        do_query(0, v, m, n, a);
        check("rh.q0valid", v, 0);
        do_commit(1, 2, 2, 25, 1'b0, ce);
        check("rh.stale.cerr", ce, 1);
        check("rh.stale.vc", int'(bus.valid_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
